// File: rtl/storage_sequencer_if.sv
// Request/command bundle between the button front end and storage_sequencer.
// The slave modport is the sequencer side; master is the requester/datapath side.
interface storage_sequencer_if;
    logic       record_req;
    logic       transfer_req;
    logic       copy_req;
    logic       auto_req;
    logic       abort;
    logic       record_cmd;
    logic       transfer_cmd;
    logic       copy_cmd;
    logic       busy;
    logic [3:0] step_count;
    logic       done;

    modport slave (
        input  record_req, transfer_req, copy_req, auto_req, abort,
        output record_cmd, transfer_cmd, copy_cmd, busy, step_count, done
    );

    modport master (
        output record_req, transfer_req, copy_req, auto_req, abort,
        input  record_cmd, transfer_cmd, copy_cmd, busy, step_count, done
    );
endinterface

// File: rtl/storage_sequencer.sv
// Arbitrates record/copy/transfer/auto requests into single-cycle storage strobes and paces auto transfers.
// Optional macro SEQ_PENDING_EN adds a one-deep slot for manual requests arriving during an auto run.
module storage_sequencer #(
    parameter int INTERVAL = 25_000_000,
    parameter int STEPS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    storage_sequencer_if.slave   bus
);
    localparam int TIMER_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(INTERVAL - 1);
    localparam logic [3:0] STEPS_V = 4'(STEPS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_reg, state_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [3:0]           step_reg, step_next;
    logic                 record_cmd_reg, record_cmd_next;
    logic                 transfer_cmd_reg, transfer_cmd_next;
    logic                 copy_cmd_reg, copy_cmd_next;
    logic                 done_reg, done_next;

`ifdef SEQ_PENDING_EN
    typedef enum logic [1:0] {P_NONE, P_REC, P_COPY, P_XFER} pend_t;
    pend_t pend_reg, pend_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            step_reg         <= '0;
            record_cmd_reg   <= 1'b0;
            transfer_cmd_reg <= 1'b0;
            copy_cmd_reg     <= 1'b0;
            done_reg         <= 1'b0;
`ifdef SEQ_PENDING_EN
            pend_reg         <= P_NONE;
`endif
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            step_reg         <= step_next;
            record_cmd_reg   <= record_cmd_next;
            transfer_cmd_reg <= transfer_cmd_next;
            copy_cmd_reg     <= copy_cmd_next;
            done_reg         <= done_next;
`ifdef SEQ_PENDING_EN
            pend_reg         <= pend_next;
`endif
        end
    end

    always_comb begin
        state_next        = state_reg;
        timer_next        = timer_reg;
        step_next         = step_reg;
        record_cmd_next   = 1'b0;
        transfer_cmd_next = 1'b0;
        copy_cmd_next     = 1'b0;
        done_next         = 1'b0;
`ifdef SEQ_PENDING_EN
        pend_next         = pend_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.abort) begin
`ifdef SEQ_PENDING_EN
                    pend_next = P_NONE;
`endif
                end
`ifdef SEQ_PENDING_EN
                // A command deferred from the last run goes out before any fresh request.
                else if (pend_reg != P_NONE) begin
                    record_cmd_next   = (pend_reg == P_REC);
                    copy_cmd_next     = (pend_reg == P_COPY);
                    transfer_cmd_next = (pend_reg == P_XFER);
                    pend_next         = P_NONE;
                end
`endif
                else if (bus.record_req) begin
                    record_cmd_next = 1'b1;
                end else if (bus.copy_req) begin
                    copy_cmd_next = 1'b1;
                end else if (bus.transfer_req) begin
                    transfer_cmd_next = 1'b1;
                end else if (bus.auto_req) begin
                    transfer_cmd_next = 1'b1;
                    step_next         = 4'd1;
                    timer_next        = RELOAD;
                    state_next        = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    // Abort wins over a simultaneous timer expiry: no strobe, no done.
                    state_next = IDLE;
                    step_next  = 4'd0;
`ifdef SEQ_PENDING_EN
                    pend_next  = P_NONE;
`endif
                end else begin
`ifdef SEQ_PENDING_EN
                    if (pend_reg == P_NONE) begin
                        if (bus.record_req)        pend_next = P_REC;
                        else if (bus.copy_req)     pend_next = P_COPY;
                        else if (bus.transfer_req) pend_next = P_XFER;
                    end
`endif
                    if (timer_reg != '0) begin
                        timer_next = timer_reg - 1'b1;
                    end else if (step_reg < STEPS_V) begin
                        transfer_cmd_next = 1'b1;
                        step_next         = step_reg + 4'd1;
                        timer_next        = RELOAD;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.record_cmd   = record_cmd_reg;
    assign bus.transfer_cmd = transfer_cmd_reg;
    assign bus.copy_cmd     = copy_cmd_reg;
    assign bus.done         = done_reg;
    assign bus.step_count   = step_reg;
    assign bus.busy         = (state_reg == RUN);
endmodule

// File: tb/tb_storage_sequencer.sv
// Directed bench for storage_sequencer with INTERVAL=4, STEPS=8.
// Expected output vector is {record,transfer,copy,busy,done,step_count[3:0]}.
module tb_storage_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    storage_sequencer_if bus ();

    storage_sequencer #(.INTERVAL(4), .STEPS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ev(input logic rec, input logic xfer, input logic cpy,
                                      input logic bsy, input logic dn, input int step);
        logic [3:0] s;
        s = 4'(step);
        return {rec, xfer, cpy, bsy, dn, s};
    endfunction

    task automatic check(input string tag, input logic [8:0] expv);
        logic [8:0] obs;
        obs = {bus.record_cmd, bus.transfer_cmd, bus.copy_cmd, bus.busy, bus.done, bus.step_count};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b required=%b", tag, obs, expv);
        end
        $display("check %s outputs=%b", tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.record_req   = 1'b0;
        bus.transfer_req = 1'b0;
        bus.copy_req     = 1'b0;
        bus.auto_req     = 1'b0;
        bus.abort        = 1'b0;
    endtask

    task automatic start_auto();
        bus.auto_req = 1'b1;
        tick();
        bus.auto_req = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check("reset", ev(0,0,0,0,0,0));
        #11 reset = 1'b0;
        tick();
        check("idle", ev(0,0,0,0,0,0));

        // Single record request: one-cycle strobe, latency 1.
        bus.record_req = 1'b1;
        tick();
        bus.record_req = 1'b0;
        check("record_cmd", ev(1,0,0,0,0,0));
        tick();
        check("record_cmd_off", ev(0,0,0,0,0,0));

        // Priority: record beats copy and transfer; losers are dropped.
        bus.record_req = 1'b1; bus.copy_req = 1'b1; bus.transfer_req = 1'b1;
        tick();
        clear_inputs();
        check("prio_rec", ev(1,0,0,0,0,0));
        tick();
        check("prio_rec_after1", ev(0,0,0,0,0,0));
        tick();
        check("prio_rec_after2", ev(0,0,0,0,0,0));

        bus.copy_req = 1'b1; bus.transfer_req = 1'b1;
        tick();
        clear_inputs();
        check("prio_copy", ev(0,0,1,0,0,0));

        bus.transfer_req = 1'b1; bus.auto_req = 1'b1;
        tick();
        clear_inputs();
        check("prio_xfer_over_auto", ev(0,1,0,0,0,0));
        tick();
        check("prio_xfer_no_run", ev(0,0,0,0,0,0));

        // Abort in IDLE drops everything sampled with it.
        bus.record_req = 1'b1; bus.abort = 1'b1;
        tick();
        clear_inputs();
        check("idle_abort_drop", ev(0,0,0,0,0,0));

        // Full auto sequence; an auto_req inside RUN is ignored.
        start_auto();
        for (int c = 1; c <= 32; c++) begin
            check($sformatf("auto_c%0d", c), ev(0, ((c - 1) % 4) == 0, 0, 1, 0, (c - 1) / 4 + 1));
            if (c == 3) bus.auto_req = 1'b1;
            tick();
            bus.auto_req = 1'b0;
        end
        check("auto_done", ev(0,0,0,0,1,8));
        tick();
        check("auto_after", ev(0,0,0,0,0,8));

        // Abort sampled together with a timer expiry: no strobe, no done.
        start_auto();
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("abort_run_c%0d", c), ev(0, ((c - 1) % 4) == 0, 0, 1, 0, (c - 1) / 4 + 1));
            if (c < 12) tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_c13", ev(0,0,0,0,0,0));
        for (int c = 14; c <= 40; c += 1) begin
            tick();
            if (c % 9 == 0) check($sformatf("abort_quiet_c%0d", c), ev(0,0,0,0,0,0));
        end

        // Manual requests during RUN; transfer_req lands in the done cycle.
        start_auto();
        for (int c = 1; c <= 32; c++) begin
            if ((c % 8) == 1)
                check($sformatf("pend_run_c%0d", c), ev(0, ((c - 1) % 4) == 0, 0, 1, 0, (c - 1) / 4 + 1));
            if (c == 7) bus.copy_req = 1'b1;
            if (c == 9) bus.record_req = 1'b1;
            tick();
            clear_inputs();
        end
        check("pend_done", ev(0,0,0,0,1,8));
        bus.transfer_req = 1'b1;
        tick();
        clear_inputs();
`ifdef SEQ_PENDING_EN
        check("pend_issue_copy", ev(0,0,1,0,0,8));
`else
        check("no_pend_xfer", ev(0,1,0,0,0,8));
`endif
        tick();
        check("pend_after", ev(0,0,0,0,0,8));

        // Asynchronous reset in the middle of a run.
        start_auto();
        for (int c = 1; c < 6; c++) tick();
        check("pre_reset_run", ev(0,0,0,1,0,2));
        #2 reset = 1'b1;
        #1;
        check("async_reset", ev(0,0,0,0,0,0));
        #2 reset = 1'b0;
        start_auto();
        check("restart_c1", ev(0,1,0,1,0,1));
        tick();
        check("restart_c2", ev(0,0,0,1,0,1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/storage_sequencer.md
# storage_sequencer

Command sequencer for the red/green storage datapath. It takes debounced one-cycle request pulses (record, transfer, copy, auto) and arbitrates between them. It issues exactly one one-cycle command strobe at a time to the storage registers. In auto mode it paces a full serial red→green transfer of STEPS shifts without further button presses.

## Interface
Parameters:
- INTERVAL, 25_000_000, cycles between successive auto-mode transfer strobes; must be ≥1.
- STEPS, 8, transfer strobes per auto sequence; range 1–15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- record_req  in  1  one-cycle pulse: load switches into red.
- transfer_req  in  1  one-cycle pulse: single red→green shift.
- copy_req  in  1  one-cycle pulse: copy red into green.
- auto_req  in  1  one-cycle pulse: start an auto transfer sequence.
- abort  in  1  level; cancels an auto sequence.
- record_cmd  out  1  registered one-cycle strobe to the datapath.
- transfer_cmd  out  1  registered one-cycle strobe to the datapath.
- copy_cmd  out  1  registered one-cycle strobe to the datapath.
- busy  out  1  high while an auto sequence runs.
- step_count  out  4  number of transfer strobes issued in the current or last auto sequence.
- done  out  1  one-cycle pulse when an auto sequence completes normally.

## Operation
- States: IDLE, RUN. Reset: IDLE. All outputs are 0 at reset, including step_count.
- At most one *_cmd is high in any cycle.
- **IDLE, abort low:** accept the highest-priority request: record > copy > transfer > auto. Lower-priority requests in the same cycle are dropped.
  - Manual request: the matching *_cmd is high for one cycle.
  - auto_req: transfer_cmd high for one cycle, step_count←1, timer←INTERVAL-1, go to RUN.
- **IDLE, abort high:** all requests sampled that cycle are dropped.
- **RUN:**
  - If timer≠0: timer decrements.
  - If timer==0 and step_count<STEPS: transfer_cmd high for one cycle, step_count increments, timer reloads to INTERVAL-1.
  - If timer==0 and step_count==STEPS: done high for one cycle, go to IDLE; step_count holds STEPS.
- **abort in RUN:** go to IDLE, step_count←0, no done. Abort beats a same-cycle timer expiry, so no strobe is issued.
- busy is 1 exactly when state==RUN.
- auto_req in RUN is ignored. A new auto_req in IDLE restarts with step_count←1.
- Manual requests in RUN are handled as described under Configuration.

## Timing
- Request sampled at edge n → *_cmd visible in cycle n+1. Latency is 1 for every command.
- Auto sequence started at edge n:
  - transfer_cmd in cycles n+1+k·INTERVAL, for k=0..STEPS-1.
  - done in cycle n+1+STEPS·INTERVAL; busy falls in that same cycle.
  - busy is high from cycle n+1 through n+STEPS·INTERVAL.
- INTERVAL=1 gives back-to-back strobes.
- abort sampled at edge m during RUN → busy=0 and step_count=0 in cycle m+1.
- reset asserted at any time → all outputs 0 immediately, with no wait for a clock edge.

## Configuration
- SEQ_PENDING_EN defined:
  - A one-deep pending slot captures the highest-priority manual request (record/copy/transfer) that arrives during RUN.
  - The first captured request is kept; later ones are dropped.
  - The pending command is issued in the cycle after done, ahead of any new request; new requests sampled in that cycle are dropped.
  - abort and reset clear the slot.
- SEQ_PENDING_EN undefined: manual requests during RUN are dropped; there is no pending slot.

## Test plan
All scenarios use INTERVAL=4, STEPS=8.
- record_req at cycle 10 in IDLE → record_cmd high in cycle 11 only; busy=0; other cmds stay 0.
- record_req, copy_req and transfer_req together in cycle 5 → only record_cmd, in cycle 6; nothing follows in later cycles.
- auto_req at cycle 0 → transfer_cmd at 1,5,9,…,29; step_count steps 1…8; busy high 1–32; done in cycle 33 only; step_count=8 afterwards.
- auto_req at 0, abort at cycle 12 → no transfer_cmd at 13; busy=0 and step_count=0 in cycle 13; done never asserts.
- auto_req at 0, copy_req at 7:
  - with SEQ_PENDING_EN → copy_cmd in cycle 34.
  - without it → copy_cmd never asserts.
- reset asserted mid-RUN between clock edges → busy, step_count and all cmds read 0 immediately. After release, auto_req restarts from step_count=1.
